// File: rtl/nthuee_scroll_ctrl.sv
// Digit scan and message scroll sequencer for the four-digit 14-segment display.
// Emits the decoder alphabet code and the active-low digit enable for the lit slot.
module nthuee_scroll_ctrl #(
   parameter int SCAN_DIV   = 50000,
   parameter int SCROLL_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pause,
   input  logic       dir,
   output logic [3:0] alphabet,
   output logic [3:0] ssd_ctl
);

   localparam int SCAN_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);

   logic [SCAN_W-1:0]   scan_cnt,   scan_cnt_nxt;
   logic [SCROLL_W-1:0] scroll_cnt, scroll_cnt_nxt;
   logic [1:0]          digit,      digit_nxt;
   logic [2:0]          ptr,        ptr_nxt;
   logic [2:0]          rom_addr;
   logic [3:0]          alphabet_nxt;
   logic [3:0]          ssd_ctl_nxt;
   logic                scan_tc;
   logic                scroll_tc;

   // "NTHUEE" followed by two blanks; blank is the decoder's all-off code.
   function automatic logic [3:0] msg_rom(input logic [2:0] addr);
      logic [3:0] code;
      case (addr)
         3'd0:    code = 4'd0;
         3'd1:    code = 4'd1;
         3'd2:    code = 4'd2;
         3'd3:    code = 4'd3;
         3'd4:    code = 4'd4;
         3'd5:    code = 4'd5;
         default: code = 4'd15;
      endcase
      return code;
   endfunction

   always_comb begin
      scan_tc        = (scan_cnt == SCAN_LAST);
      scan_cnt_nxt   = scan_tc ? '0 : scan_cnt + SCAN_W'(1);
      digit_nxt      = scan_tc ? digit + 2'd1 : digit;

      scroll_tc      = !pause && (scroll_cnt == SCROLL_LAST);
      scroll_cnt_nxt = scroll_cnt;
      ptr_nxt        = ptr;
      if (!pause) begin
         scroll_cnt_nxt = scroll_tc ? '0 : scroll_cnt + SCROLL_W'(1);
      end
      if (scroll_tc) begin
         ptr_nxt = dir ? ptr - 3'd1 : ptr + 3'd1;
      end

      // Outputs are derived from next-state so they move on the same edge as digit/ptr.
      rom_addr     = ptr_nxt + {1'b0, digit_nxt};
      alphabet_nxt = msg_rom(rom_addr);
      ssd_ctl_nxt  = ~(4'b1000 >> digit_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt   <= '0;
         scroll_cnt <= '0;
         digit      <= 2'd0;
         ptr        <= 3'd0;
         alphabet   <= 4'd0;
         ssd_ctl    <= 4'b0111;
      end else begin
         scan_cnt   <= scan_cnt_nxt;
         scroll_cnt <= scroll_cnt_nxt;
         digit      <= digit_nxt;
         ptr        <= ptr_nxt;
         alphabet   <= alphabet_nxt;
         ssd_ctl    <= ssd_ctl_nxt;
      end
   end

endmodule

// File: tb/tb_nthuee_scroll_ctrl.sv
// Bench for nthuee_scroll_ctrl: directed test-plan scenarios plus randomized pause/dir
// traffic, all compared against an edge-counting message model.
module tb_nthuee_scroll_ctrl;

   localparam int SCAN   = 4;
   localparam int SCROLL = 32;

   logic       clk;
   logic       rst_n;
   logic       pause;
   logic       dir;
   logic [3:0] alphabet;
   logic [3:0] ssd_ctl;

   int checks = 0;
   int errors = 0;

   // Reference model: edges since reset, unpaused cycles, and message offset.
   int m_edge;
   int m_unp;
   int m_ptr;
   int msg [8] = '{0, 1, 2, 3, 4, 5, 15, 15};

   nthuee_scroll_ctrl #(.SCAN_DIV(SCAN), .SCROLL_DIV(SCROLL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pause    (pause),
      .dir      (dir),
      .alphabet (alphabet),
      .ssd_ctl  (ssd_ctl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_alpha();
      int d;
      d = (m_edge / SCAN) % 4;
      return 4'(msg[(m_ptr + d) % 8]);
   endfunction

   function automatic logic [3:0] exp_ssd();
      logic [3:0] v;
      int d;
      d = (m_edge / SCAN) % 4;
      v = 4'b1111;
      v[3-d] = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      m_edge = 0;
      m_unp  = 0;
      m_ptr  = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset_alpha", alphabet, 4'd0);
      chk("reset_ssd", ssd_ctl, 4'b0111);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One rising edge: advance the model with the inputs held across the edge, then compare.
   task automatic tick();
      int ones;
      @(posedge clk);
      m_edge++;
      if (!pause) begin
         m_unp++;
         if (m_unp % SCROLL == 0) m_ptr = (m_ptr + (dir ? 7 : 1)) % 8;
      end
      #1;
      chk("model_alpha", alphabet, exp_alpha());
      chk("model_ssd", ssd_ctl, exp_ssd());
      ones = $countones(~ssd_ctl);
      checks++;
      assert (ones == 1) else begin
         errors++;
         $error("FAIL onehot: observed %b expected exactly one low bit", ssd_ctl);
      end
   endtask

   task automatic run_to(input int target);
      while (m_edge < target) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      pause = 1'b0;
      dir   = 1'b0;
      model_reset();
      #12;
      chk("por_alpha", alphabet, 4'd0);
      chk("por_ssd", ssd_ctl, 4'b0111);

      // Scenario 1: scan order from reset
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         case (k)
            3:  begin chk("s1_e3_a", alphabet, 4'd0); chk("s1_e3_s", ssd_ctl, 4'b0111); end
            4:  begin chk("s1_e4_a", alphabet, 4'd1); chk("s1_e4_s", ssd_ctl, 4'b1011); end
            8:  begin chk("s1_e8_a", alphabet, 4'd2); chk("s1_e8_s", ssd_ctl, 4'b1101); end
            12: begin chk("s1_e12_a", alphabet, 4'd3); chk("s1_e12_s", ssd_ctl, 4'b1110); end
            16: begin chk("s1_e16_a", alphabet, 4'd0); chk("s1_e16_s", ssd_ctl, 4'b0111); end
            default: ;
         endcase
      end

      // Scenario 2: first left step coincides with digit wrap
      run_to(31);
      chk("s2_e31_a", alphabet, 4'd3);
      tick();
      chk("s2_e32_a", alphabet, 4'd1);
      chk("s2_e32_s", ssd_ctl, 4'b0111);
      run_to(36); chk("s2_e36_a", alphabet, 4'd2);
      run_to(40); chk("s2_e40_a", alphabet, 4'd3);
      run_to(44); chk("s2_e44_a", alphabet, 4'd4);

      // Scenario 3: right scroll wraps ptr to 7
      dir = 1'b1;
      do_reset();
      run_to(32); chk("s3_e32_a", alphabet, 4'd15); chk("s3_e32_s", ssd_ctl, 4'b0111);
      run_to(36); chk("s3_e36_a", alphabet, 4'd0);  chk("s3_e36_s", ssd_ctl, 4'b1011);
      run_to(40); chk("s3_e40_a", alphabet, 4'd1);  chk("s3_e40_s", ssd_ctl, 4'b1101);
      run_to(44); chk("s3_e44_a", alphabet, 4'd2);  chk("s3_e44_s", ssd_ctl, 4'b1110);

      // Scenario 4: pause for 40 cycles delays the first step to edge 72
      dir = 1'b0;
      do_reset();
      run_to(20);
      pause = 1'b1;
      run_to(60);
      pause = 1'b0;
      run_to(71); chk("s4_e71_a", alphabet, 4'd1); chk("s4_e71_s", ssd_ctl, 4'b1011);
      tick();     chk("s4_e72_a", alphabet, 4'd3); chk("s4_e72_s", ssd_ctl, 4'b1101);

      // Scenario 5: full rotation, digit-0 code at each step boundary
      do_reset();
      chk("s5_step0", alphabet, 4'd0);
      for (int s = 1; s <= 8; s++) begin
         logic [3:0] want;
         run_to(s * SCROLL);
         want = 4'(msg[s % 8]);
         chk($sformatf("s5_step%0d", s), alphabet, want);
         chk($sformatf("s5_ssd%0d", s), ssd_ctl, 4'b0111);
      end

      // Scenario 6: asynchronous reset between edges at ptr=3, digit=2
      do_reset();
      run_to(105);
      chk("s6_pre_a", alphabet, 4'd5);
      chk("s6_pre_s", ssd_ctl, 4'b1101);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("s6_async_a", alphabet, 4'd0);
      chk("s6_async_s", ssd_ctl, 4'b0111);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] wa;
         logic [3:0] ws;
         tick();
         wa = 4'((k / 4) % 4);
         ws = ~(4'b1000 >> ((k / 4) % 4));
         chk($sformatf("s6_rep_a%0d", k), alphabet, wa);
         chk($sformatf("s6_rep_s%0d", k), ssd_ctl, ws);
      end

      // Randomized pause/dir traffic against the model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         pause = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
